// File: rtl/ahb_pkg.sv
// AHB-Lite encodings and the ahb_mem_sub FSM state type shared by the memory subordinate.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } mem_state_e;

  function automatic logic is_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// DEPTH x DATA_WIDTH storage built from one byte-wide array per lane: strobed write port,
// asynchronous read port, no reset on contents.
module ahb_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [DATA_WIDTH/8-1:0]    wstrb_i,
  input  logic [$clog2(DEPTH)-1:0]   widx_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   ridx_i,
  output logic [DATA_WIDTH-1:0]      rdata_o
);

  localparam int BPW = DATA_WIDTH / 8;

  for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we_i && wstrb_i[gi]) begin
        lane_mem[widx_i] <= wdata_i[gi*8 +: 8];
      end
    end

    assign rdata_o[gi*8 +: 8] = lane_mem[ridx_i];
  end

endmodule

// File: rtl/ahb_mem_sub.sv
// AHB-Lite memory subordinate: address-phase capture, wait-state FSM and byte-strobed memory.
// Define AHB_MEM_SUB_ERR_RESP_EN to build the two-cycle ERROR response for bad transfers.
module ahb_mem_sub
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL,
  input  logic                    HREADY,
  input  logic                    HWRITE,
  input  logic [1:0]              HTRANS,
  input  logic [2:0]              HSIZE,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic [DATA_WIDTH/8-1:0] HWSTRB,
  output logic                    HREADYOUT,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    HRESP
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BPW);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;

  mem_state_e         state_q, state_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               write_q, write_d;
  logic               can_accept;
  logic               accept;
  logic               bad_xfer;
  logic               mem_we;
  logic [DATA_WIDTH-1:0] rd_word;

  // New address phases are only taken while the previous data phase is completing.
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign accept     = HSEL && HREADY && is_active(HTRANS) && can_accept;

`ifdef AHB_MEM_SUB_ERR_RESP_EN
  logic [ADDR_WIDTH-1:0] align_mask;
  assign align_mask = (ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1);
  assign bad_xfer   = (HSIZE > 3'(OFF_W))
                   || ((HADDR & align_mask) != '0)
                   || ((HADDR >> (IDX_W + OFF_W)) != '0);
`else
  // Without the error response, high address bits wrap and low offset bits are ignored.
  assign bad_xfer = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{HSIZE, HADDR, bad_xfer};

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    if (state_q == ST_WAIT) begin
      if (wcnt_q == '0) begin
        state_d = ST_DATA;
      end else begin
        wcnt_d = wcnt_q - 1'b1;
      end
    end
`ifdef AHB_MEM_SUB_ERR_RESP_EN
    else if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end
`endif
    else if (accept) begin
      idx_d   = HADDR[IDX_W+OFF_W-1:OFF_W];
      write_d = HWRITE;
`ifdef AHB_MEM_SUB_ERR_RESP_EN
      if (bad_xfer) begin
        state_d = ST_ERR1;
      end else
`endif
      if (WAIT_STATES == 0) begin
        state_d = ST_DATA;
      end else begin
        state_d = ST_WAIT;
        wcnt_d  = CNT_W'(WAIT_STATES - 1);
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  // Writes land at the end of the data cycle, so the next data phase already sees them.
  assign mem_we = (state_q == ST_DATA) && write_q;

  ahb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk     (HCLK),
    .we_i    (mem_we),
    .wstrb_i (HWSTRB),
    .widx_i  (idx_q),
    .wdata_i (HWDATA),
    .ridx_i  (idx_q),
    .rdata_o (rd_word)
  );

  assign HREADYOUT = (state_q != ST_WAIT) && (state_q != ST_ERR1);
  assign HRDATA    = ((state_q == ST_DATA) && !write_q) ? rd_word : '0;

`ifdef AHB_MEM_SUB_ERR_RESP_EN
  assign HRESP = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
  assign HRESP = HRESP_OKAY;
`endif

endmodule

// File: tb/tb_ahb_mem_sub.sv
// Self-checking bench for ahb_mem_sub: three instances (0, 2 and 3 wait states) driven by
// directed and random transfer lists, checked against a word-array reference model.
`timescale 1ns/1ps
module tb_ahb_mem_sub;
  import ahb_pkg::*;

  localparam int NDUT = 3;

  typedef struct {
    int          kind;   // 0 read, 1 write, 2 idle/busy, 3 unselected
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } op_t;

  logic        clk = 1'b0;
  logic        rst       [NDUT];
  logic        hsel      [NDUT];
  logic        hwrite    [NDUT];
  logic [1:0]  htrans    [NDUT];
  logic [2:0]  hsize     [NDUT];
  logic [31:0] haddr     [NDUT];
  logic [31:0] hwdata    [NDUT];
  logic [3:0]  hwstrb    [NDUT];
  logic        hreadyout [NDUT];
  logic [31:0] hrdata    [NDUT];
  logic        hresp     [NDUT];

  op_t         ops [$];
  logic [31:0] mdl [NDUT][256];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int WS = (gi == 0) ? 0 : ((gi == 1) ? 2 : 3);
    ahb_mem_sub #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .DEPTH       (256),
      .WAIT_STATES (WS)
    ) u_dut (
      .HCLK      (clk),
      .HRESET    (rst[gi]),
      .HSEL      (hsel[gi]),
      .HREADY    (hreadyout[gi]),
      .HWRITE    (hwrite[gi]),
      .HTRANS    (htrans[gi]),
      .HSIZE     (hsize[gi]),
      .HADDR     (haddr[gi]),
      .HWDATA    (hwdata[gi]),
      .HWSTRB    (hwstrb[gi]),
      .HREADYOUT (hreadyout[gi]),
      .HRDATA    (hrdata[gi]),
      .HRESP     (hresp[gi])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  function automatic bit is_err(input op_t o);
`ifdef AHB_MEM_SUB_ERR_RESP_EN
    if (o.kind >= 2) return 1'b0;
    return (o.size > 3'd2) || ((o.addr % (32'd1 << o.size)) != 0) || (o.addr >= 32'd1024);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic add_op(input int kind, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [3:0] strb);
    op_t o;
    o.kind = kind; o.addr = addr; o.size = size; o.wdata = wdata; o.strb = strb;
    ops.push_back(o);
  endtask

  task automatic drive_addr(input int d, input int i);
    if (i >= ops.size()) begin
      hsel[d] = 1'b0; htrans[d] = HTRANS_IDLE; hwrite[d] = 1'b0;
      hsize[d] = 3'd0; haddr[d] = $urandom;
    end else begin
      haddr[d] = ops[i].addr;
      hsize[d] = ops[i].size;
      case (ops[i].kind)
        0, 1: begin
          hsel[d] = 1'b1; hwrite[d] = (ops[i].kind == 1);
          htrans[d] = $urandom_range(0, 1) ? HTRANS_NONSEQ : HTRANS_SEQ;
        end
        2: begin
          hsel[d] = 1'b1; hwrite[d] = 1'($urandom_range(0, 1));
          htrans[d] = $urandom_range(0, 1) ? HTRANS_BUSY : HTRANS_IDLE;
        end
        default: begin
          hsel[d] = 1'b0; hwrite[d] = 1'($urandom_range(0, 1));
          htrans[d] = HTRANS_NONSEQ;
        end
      endcase
    end
  endtask

  task automatic finish_op(input int d, input op_t o, input int lows);
    bit          err;
    int          idx;
    int          exp_lows;
    logic [31:0] exp_rd;
    err      = is_err(o);
    idx      = (o.addr >> 2) % 256;
    exp_lows = (o.kind >= 2) ? 0 : (err ? 1 : ws_of(d));
    exp_rd   = (o.kind == 0 && !err) ? mdl[d][idx] : 32'h0;
    check($sformatf("d%0d k%0d @%08h low cycles", d, o.kind, o.addr), 32'(lows), 32'(exp_lows));
    check($sformatf("d%0d k%0d @%08h hresp", d, o.kind, o.addr), {31'b0, hresp[d]}, {31'b0, err});
    check($sformatf("d%0d k%0d @%08h hrdata", d, o.kind, o.addr), hrdata[d], exp_rd);
    $display("[TB] d%0d kind=%0d addr=%08h size=%0d strb=%h lows=%0d resp=%0d rdata=%08h",
             d, o.kind, o.addr, o.size, o.strb, lows, hresp[d], hrdata[d]);
    if (o.kind == 1 && !err)
      for (int b = 0; b < 4; b++)
        if (o.strb[b]) mdl[d][idx][b*8 +: 8] = o.wdata[b*8 +: 8];
  endtask

  task automatic finish_sim();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Pipelined driver: runs the queued ops on instance d; call just after a rising edge.
  task automatic run_ops(input int d);
    int   n;
    int   ap;
    int   dp;
    int   lows;
    logic rdy;
    n = ops.size(); ap = 0; dp = -1; lows = 0;
    drive_addr(d, 0);
    while (ap < n || dp >= 0) begin
      @(negedge clk);
      rdy = hreadyout[d];
      if (dp >= 0) begin
        if (rdy) begin
          finish_op(d, ops[dp], lows);
        end else begin
          lows++;
          check($sformatf("d%0d stall hresp", d), {31'b0, hresp[d]}, {31'b0, is_err(ops[dp])});
          check($sformatf("d%0d stall hrdata", d), hrdata[d], 32'h0);
          if (lows > 20) begin
            check($sformatf("d%0d stall bound", d), 32'(lows), 32'd20);
            finish_sim();
          end
        end
      end
      @(posedge clk); #1;
      if (rdy) begin
        if (ap < n) begin dp = ap; ap++; end else dp = -1;
        lows = 0;
        drive_addr(d, ap);
        if (dp >= 0) begin
          hwdata[d] = ops[dp].wdata; hwstrb[d] = ops[dp].strb;
        end else begin
          hwdata[d] = $urandom; hwstrb[d] = 4'($urandom);
        end
      end
    end
    ops.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    int          k;
    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b1; hsel[d] = 1'b0; hwrite[d] = 1'b0; htrans[d] = HTRANS_IDLE;
      hsize[d] = 3'd2; haddr[d] = '0; hwdata[d] = '0; hwstrb[d] = '0;
    end

    // Reset, then idle cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("d%0d reset hreadyout", d), {31'b0, hreadyout[d]}, 32'd1);
      check($sformatf("d%0d reset hresp", d), {31'b0, hresp[d]}, 32'd0);
      check($sformatf("d%0d reset hrdata", d), hrdata[d], 32'h0);
    end
    @(posedge clk); #1;
    for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        check($sformatf("d%0d idle hreadyout", d), {31'b0, hreadyout[d]}, 32'd1);
        check($sformatf("d%0d idle hresp", d), {31'b0, hresp[d]}, 32'd0);
        check($sformatf("d%0d idle hrdata", d), hrdata[d], 32'h0);
      end
    end
    @(posedge clk); #1;

    // Fill every word so later reads have known contents
    for (int d = 0; d < NDUT; d++) begin
      for (int w = 0; w < 256; w++) add_op(1, 32'(w * 4), 3'd2, $urandom, 4'hF);
      run_ops(d);
    end

    // Word write/read, then pipelined write/read, zero wait states
    add_op(1, 32'h10, 3'd2, 32'hDEADBEEF, 4'hF);
    add_op(0, 32'h10, 3'd2, 32'h0, 4'h0);
    run_ops(0);
    add_op(1, 32'h20, 3'd2, 32'hA5A5A5A5, 4'hF);
    add_op(0, 32'h20, 3'd2, 32'h0, 4'h0);
    run_ops(0);

    // Strobed write over DEADBEEF with two wait states
    add_op(1, 32'h10, 3'd2, 32'hDEADBEEF, 4'hF);
    add_op(1, 32'h10, 3'd2, 32'h11223344, 4'b0101);
    add_op(0, 32'h10, 3'd2, 32'h0, 4'h0);
    run_ops(1);

    // Out-of-range read and unaligned word write, then read back word 0
    for (int d = 0; d < 2; d++) begin
      add_op(0, 32'h400, 3'd2, 32'h0, 4'h0);
      add_op(1, 32'h02, 3'd2, $urandom, 4'hF);
      add_op(0, 32'h00, 3'd2, 32'h0, 4'h0);
      add_op(1, 32'h04, 3'd3, $urandom, 4'hF);
      add_op(0, 32'h04, 3'd2, 32'h0, 4'h0);
      run_ops(d);
    end

    // Random mixed traffic
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 120; i++) begin
        k    = $urandom_range(0, 9);
        addr = 32'($urandom_range(0, 255) * 4);
        if ($urandom_range(0, 9) < 3) addr = addr + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) addr = addr + 32'h400;
        add_op((k < 4) ? 0 : ((k < 8) ? 1 : ((k == 8) ? 2 : 3)), addr,
               ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 3)) : 3'd2,
               $urandom, 4'($urandom));
      end
      run_ops(d);
    end

    // Reset during the second wait cycle of a write to 0x30
    hsel[2] = 1'b1; htrans[2] = HTRANS_NONSEQ; hwrite[2] = 1'b1;
    haddr[2] = 32'h30; hsize[2] = 3'd2;
    @(posedge clk); #1;
    hsel[2] = 1'b0; htrans[2] = HTRANS_IDLE; hwdata[2] = ~mdl[2][12]; hwstrb[2] = 4'hF;
    @(negedge clk);
    check("d2 abort wait1 hreadyout", {31'b0, hreadyout[2]}, 32'd0);
    @(posedge clk); #1;
    check("d2 abort wait2 hreadyout", {31'b0, hreadyout[2]}, 32'd0);
    rst[2] = 1'b1;
    #1;
    check("d2 abort reset hreadyout", {31'b0, hreadyout[2]}, 32'd1);
    check("d2 abort reset hresp", {31'b0, hresp[2]}, 32'd0);
    check("d2 abort reset hrdata", hrdata[2], 32'h0);
    @(posedge clk); @(posedge clk); #1;
    check("d2 held reset hreadyout", {31'b0, hreadyout[2]}, 32'd1);
    rst[2] = 1'b0;
    @(posedge clk); #1;
    add_op(0, 32'h30, 3'd2, 32'h0, 4'h0);
    run_ops(2);

    finish_sim();
  end

endmodule

// File: doc/ahb_mem_sub.md
AHB_MEM_SUB -- requirements
Module: ahb_mem_sub

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning byte address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning data bus width; it is 32 or 64.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning the number of DATA_WIDTH words; it is a power of 2.
REQ-004 The block SHALL have parameter WAIT_STATES, default 0, meaning the number of HREADYOUT-low cycles per OKAY data phase (0..15).
REQ-005 The block SHALL use one clock, HCLK, and an asynchronous active-high reset, HRESET.
REQ-006 The ports SHALL be:
- HCLK  in  1  clock.
- HRESET  in  1  asynchronous active-high reset.
- HSEL  in  1  subordinate select.
- HREADY  in  1  bus ready.
- HWRITE  in  1  write when 1.
- HTRANS  in  2  transfer type.
- HSIZE  in  3  transfer size.
- HADDR  in  ADDR_WIDTH  byte address.
- HWDATA  in  DATA_WIDTH  write data, data phase.
- HWSTRB  in  DATA_WIDTH/8  byte-lane enables, data phase.
- HREADYOUT  out  1  data phase complete.
- HRDATA  out  DATA_WIDTH  read data.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

Function
REQ-007 A transfer SHALL be accepted on a rising HCLK edge when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; at that edge HADDR, HWRITE and HSIZE are registered.
REQ-008 IDLE or BUSY transfers, and unselected cycles, SHALL get a zero-wait OKAY response.
REQ-009 The FSM SHALL have states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-010 Transitions on an accepted OKAY transfer:
- WAIT_STATES=0: go to DATA.
- Otherwise: go to WAIT, hold HREADYOUT=0 for WAIT_STATES cycles, then go to DATA.
REQ-011 In DATA, HREADYOUT SHALL be 1 and HRESP 0.
REQ-012 When DATA coincides with a new accept, the FSM SHALL re-enter WAIT or DATA; otherwise it SHALL return to IDLE.
REQ-013 In a read DATA cycle, HRDATA SHALL equal mem[word index]; outside read DATA cycles, HRDATA SHALL be 0.
REQ-014 A write SHALL commit at the DATA-cycle edge, byte lane i only when HWSTRB[i]=1, so a read of the same address in the next data phase returns the new data.
REQ-015 The word index SHALL be HADDR[log2(DEPTH)+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)].
REQ-016 An error transfer SHALL be any of:
- HSIZE > log2(DATA_WIDTH/8).
- HADDR not aligned to 2^HSIZE.
- HADDR >= DEPTH*DATA_WIDTH/8.
REQ-017 An error transfer SHALL go to ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); no wait states SHALL be inserted and no memory write SHALL occur.
REQ-018 A transfer accepted during ERR2 SHALL be processed normally.

Reset
REQ-019 While HRESET=1, outputs SHALL be HREADYOUT=1, HRESP=0 and HRDATA=0; the FSM SHALL be IDLE and the wait counter 0.
REQ-020 A reset asserted mid-transfer SHALL abort it: a pending write is discarded and the wait count is cleared.
REQ-021 Memory contents SHALL NOT be reset.

Configuration
REQ-022 Macro AHB_MEM_SUB_ERR_RESP_EN defined: REQ-016 to REQ-018 apply.
REQ-023 Macro AHB_MEM_SUB_ERR_RESP_EN undefined:
- HRESP is tied to 0 and ERR1/ERR2 are not built.
- Out-of-range addresses wrap modulo DEPTH words.
- Unaligned addresses are aligned down.
- An oversize HSIZE is treated as a full word with normal wait states.

Structure
REQ-024 Package ahb_pkg SHALL hold:
- HTRANS encodings: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
- HSIZE encodings: BYTE=3'b000, HALF=3'b001, WORD=3'b010, DWORD=3'b011.
- HRESP values: OKAY=0, ERROR=1.
- The ahb_mem_sub FSM state enum.
REQ-025 Sub-module ahb_mem_array SHALL implement the DEPTH x DATA_WIDTH byte-strobed array with one write port and an asynchronous read port; the FSM and wait counter SHALL stay in ahb_mem_sub.

Verification
REQ-026 Reset, then idle: HRESET pulse, HTRANS=IDLE -> HREADYOUT=1, HRESP=0, HRDATA=0 every cycle.
REQ-027 Word write/read: WAIT_STATES=0, write 0x0000_0010 = 0xDEADBEEF, HWSTRB=4'hF, then read 0x10 -> HRDATA=0xDEADBEEF in the first data cycle.
REQ-028 Strobed write with wait states: WAIT_STATES=2, write 0x10 = 0x11223344 with HWSTRB=4'b0101 over 0xDEADBEEF, then read 0x10:
- Each data phase shows 2 HREADYOUT-low cycles, then 1 high.
- Read returns 0xDE22BE44.
REQ-029 Back-to-back pipelined write 0x20 = 0xA5A5A5A5 then read 0x20 -> read returns 0xA5A5A5A5 with no extra stall.
REQ-030 Error response, macro defined: read 0x0000_0400 with DEPTH=256 -> ERR1 (HREADYOUT=0, HRESP=1), ERR2 (HREADYOUT=1, HRESP=1); an unaligned WORD write to 0x02 gives the same response and leaves memory unchanged.
REQ-031 Reset mid-transfer: WAIT_STATES=3, assert HRESET during the second wait cycle of a write to 0x30 -> outputs take reset values and a later read of 0x30 returns the old contents.
